// File: rtl/tremolo_pkg.sv
// rtl/tremolo_pkg.sv - shared widths and gain law for the tremolo modulator
package tremolo_pkg;

  localparam int TREM_WIDTH   = 24;
  localparam int TREM_DEPTH_W = 8;

  // g = 2^W - ((depth * (2^W - u)) >> DEPTH_W), with u the offset-binary LFO
  function automatic logic [TREM_WIDTH:0] trem_gain(
    input logic [TREM_WIDTH-1:0]   lfo,
    input logic [TREM_DEPTH_W-1:0] depth
  );
    logic [TREM_WIDTH-1:0]              u;
    logic [TREM_WIDTH:0]                d;
    logic [TREM_DEPTH_W+TREM_WIDTH:0]   prod;
    logic [TREM_WIDTH:0]                r;
    u    = {~lfo[TREM_WIDTH-1], lfo[TREM_WIDTH-2:0]};
    d    = {1'b1, {TREM_WIDTH{1'b0}}} - {1'b0, u};
    prod = {{(TREM_WIDTH+1){1'b0}}, depth} * {{TREM_DEPTH_W{1'b0}}, d};
    r    = (TREM_WIDTH+1)'(prod >> TREM_DEPTH_W);
    return {1'b1, {TREM_WIDTH{1'b0}}} - r;
  endfunction

endpackage

// File: rtl/tremolo_gain.sv
// rtl/tremolo_gain.sv - registered stage-1 gain from LFO and depth
module tremolo_gain
  import tremolo_pkg::*;
#(
  parameter int WIDTH   = TREM_WIDTH,
  parameter int DEPTH_W = TREM_DEPTH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [WIDTH-1:0]   lfo,
  input  logic [DEPTH_W-1:0] depth,
  output logic [WIDTH:0]     g
);

  localparam logic [WIDTH:0] FULL_SCALE = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0]         u;
  logic [WIDTH:0]           d;
  logic [DEPTH_W+WIDTH:0]   prod;
  logic [WIDTH:0]           r;
  logic [WIDTH:0]           g_d;
  logic [WIDTH:0]           g_q;

  always_comb begin
    u    = {~lfo[WIDTH-1], lfo[WIDTH-2:0]};
    d    = FULL_SCALE - {1'b0, u};
    prod = {{(WIDTH+1){1'b0}}, depth} * {{DEPTH_W{1'b0}}, d};
    r    = (WIDTH+1)'(prod >> DEPTH_W);
    g_d  = g_q;
    if (ce) begin
      g_d = FULL_SCALE - r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= '0;
    end else begin
      g_q <= g_d;
    end
  end

  assign g = g_q;

endmodule

// File: rtl/tremolo_mod.sv
// rtl/tremolo_mod.sv - 3-stage valid/ready tremolo amplitude modulator
module tremolo_mod
  import tremolo_pkg::*;
#(
  parameter int WIDTH   = TREM_WIDTH,
  parameter int DEPTH_W = TREM_DEPTH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [WIDTH-1:0]   lfo,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready
);

  localparam int PW = 2 * WIDTH + 2;

  logic               ce;
  logic [DEPTH_W-1:0] depth_eff;
  logic [WIDTH:0]     g;

  logic               s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0]   s1_data_d,  s1_data_q;
  logic               s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0]   s2_data_d,  s2_data_q;
  logic               m_valid_d,  m_valid_q;
  logic [WIDTH-1:0]   m_data_d,   m_data_q;

  logic signed [PW-1:0] op_a;
  logic signed [PW-1:0] op_b;
  logic signed [PW-1:0] prod;

  assign ce      = !m_valid_q || m_ready;
  assign s_ready = ce;

  // Bypass reuses the depth=0 path, which yields unity gain exactly.
  assign depth_eff = en ? depth : '0;

  tremolo_gain #(
    .WIDTH   (WIDTH),
    .DEPTH_W (DEPTH_W)
  ) u_gain (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .lfo   (lfo),
    .depth (depth_eff),
    .g     (g)
  );

  always_comb begin
    op_a = $signed({{(WIDTH+2){s1_data_q[WIDTH-1]}}, s1_data_q});
    op_b = $signed({{(WIDTH+1){1'b0}}, g});
    prod = op_a * op_b;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;

    if (ce) begin
      s1_valid_d = s_valid;
      s1_data_d  = s_data;
      s2_valid_d = s1_valid_q;
      s2_data_d  = WIDTH'(prod >>> WIDTH);
      m_valid_d  = s2_valid_q;
      if (s2_valid_q) begin
        m_data_d = s2_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_tremolo_mod.sv
// tb/tb_tremolo_mod.sv - scoreboard bench for tremolo_mod
module tb_tremolo_mod;
  import tremolo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  depth;
  logic [23:0] lfo;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [23:0] data;
    logic        lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  tremolo_mod #(.WIDTH(24), .DEPTH_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .depth   (depth),
    .lfo     (lfo),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h required=none", m_data);
        end else begin
          e = sb.pop_front();
          if (m_data !== e.data) begin
            errors++;
            $display("FAIL out_data got=%h required=%h", m_data, e.data);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.acc != 2) begin
              errors++;
              $display("FAIL latency got=%0d required=2", cyc - e.acc);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [23:0] d, input logic e, input logic [7:0] dp,
                      input logic [23:0] l, input logic push, input logic [23:0] ex,
                      input logic lat);
    int  n;
    logic done;
    exp_t ent;
    n = 0;
    done = 1'b0;
    s_data = d; en = e; depth = dp; lfo = l; s_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_ready && !rst) begin
        if (push) begin
          ent.data = ex; ent.lat = lat; ent.acc = cyc + 1;
          sb.push_back(ent);
        end
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          checks++; errors++;
          $display("FAIL send_timeout got=s_ready_low required=accept");
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d_pending required=0", sb.size());
      sb.delete();
    end
  endtask

  logic [23:0] st_in  [8] = '{24'h000400, 24'hFFFC00, 24'h000004, 24'hFFFFFC,
                              24'h000005, 24'hFFFFFB, 24'h400000, 24'hFFFFFF};
  logic [23:0] st_exp [8] = '{24'h000300, 24'hFFFD00, 24'h000003, 24'hFFFFFD,
                              24'h000003, 24'hFFFFFC, 24'h300000, 24'hFFFFFF};

  initial begin
    logic [23:0]        held;
    logic [24:0]        gm;
    logic signed [49:0] pm;
    logic [23:0]        sm;
    logic [23:0]        exm;
    rst = 1'b1; en = 1'b1; depth = '0; lfo = '0; s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", {31'b0, m_valid}, 32'd0);
    check("reset_m_data", {8'b0, m_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(24'd1000,   1'b1, 8'd0,   24'h800000, 1'b1, 24'd1000,   1'b1);
    drain();
    send(24'h100000, 1'b1, 8'd255, 24'h800000, 1'b1, 24'h001000, 1'b1);
    send(24'hFFF000, 1'b1, 8'd128, 24'h000000, 1'b1, 24'hFFF400, 1'b1);
    send(24'h123456, 1'b1, 8'd255, 24'h7FFFFF, 1'b1, 24'h123456, 1'b1);
    send(24'h800000, 1'b1, 8'd0,   24'h000000, 1'b1, 24'h800000, 1'b1);
    send(24'h7FFFFF, 1'b0, 8'd255, 24'h800000, 1'b1, 24'h7FFFFF, 1'b1);
    send(24'h7FFFFF, 1'b1, 8'd255, 24'h800000, 1'b1, 24'h007FFF, 1'b1);
    sm  = 24'hCBA988;
    gm  = trem_gain(24'h123456, 8'd77);
    pm  = $signed({{26{sm[23]}}, sm}) * $signed({25'b0, gm});
    exm = pm[47:24];
    send(sm, 1'b1, 8'd77, 24'h123456, 1'b1, exm, 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(st_in[i], 1'b1, 8'd128, 24'h000000, 1'b1, st_exp[i], 1'b0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        held = m_data;
        check("stall_m_valid", {31'b0, m_valid}, 32'd1);
        check("stall_s_ready", {31'b0, s_ready}, 32'd0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("stall_hold_data", {8'b0, m_data}, {8'b0, held});
          check("stall_s_ready", {31'b0, s_ready}, 32'd0);
        end
        @(posedge clk); #1 m_ready = 1'b1;
      end
    join
    drain();

    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(24'h000100, 1'b1, 8'd0, 24'h000000, 1'b0, 24'h0, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_flush_m_data", {8'b0, m_data}, 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(24'h000200, 1'b1, 8'd128, 24'h000000, 1'b1, 24'h000180, 1'b1);
    drain();
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tremolo_mod.md
Name: tremolo_mod

Overview:
- Amplitude modulator downstream of the cosine NCO.
- Multiplies a signed audio sample stream by a gain derived from the NCO's `wav` output (LFO) and a depth control. The result is a tremolo effect.
- Sits in the effects chain between the audio input stream and the next effect or the DAC. Valid/ready streaming on both sides, 3-stage pipeline, throughput of one sample per cycle.

Parameters:
- WIDTH, 24, width of audio samples and of the LFO input (two's complement).
- DEPTH_W, 8, width of the depth control (unsigned).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous to clk, active-high
- en  in  1  1 = apply modulation, 0 = bypass (sample passes unchanged); sampled with each accepted sample
- depth  in  DEPTH_W  modulation depth, unsigned, 0 = none, 2^DEPTH_W-1 = maximum; sampled with each accepted sample
- lfo  in  WIDTH  signed LFO value (the NCO's `wav`), free-running, no handshake; sampled with each accepted sample
- s_data  in  WIDTH  signed input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- m_data  out  WIDTH  signed output sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output

Behaviour:
- Reset (synchronous, active-high):
  - All stage valid bits clear; m_valid=0; m_data=0.
  - Reset mid-operation discards all in-flight samples. No output appears for them.
  - s_ready may be 1 during reset, but samples presented during a reset cycle are dropped.
- Handshake:
  - Transfer occurs on a clk edge where valid&&ready.
  - Global advance ce = !m_valid || m_ready, and s_ready = ce (combinational).
  - When ce=0 every stage holds its data and valid bit.
  - m_data and m_valid hold stable while m_valid && !m_ready.
- Pipeline and latency:
  - Stage 1 captures s_data, en, depth and lfo on acceptance, and computes the gain.
  - Stage 2 forms the product.
  - Stage 3 is the output register.
  - A sample accepted at edge N is presented on m_data/m_valid after edge N+2, given no stalls.
  - Bubbles propagate as valid=0. Back-to-back samples give one output per cycle.
- Arithmetic (all exact, no rounding):
  - u = lfo + 2^(WIDTH-1), taken as unsigned WIDTH bits (invert the MSB), range [0, 2^WIDTH-1].
  - d = 2^WIDTH - u, range [1, 2^WIDTH], WIDTH+1 bits.
  - r = (depth * d) >> DEPTH_W, an unsigned floor shift.
  - g = 2^WIDTH - r, unsigned WIDTH+1 bits, range [2^(WIDTH-DEPTH_W), 2^WIDTH].
  - p = s_data (signed) * {0,g} (zero-extended to signed), 2*WIDTH+2 bits.
  - out = p >>> WIDTH (arithmetic, floor), truncated to WIDTH bits. No overflow is possible because g ≤ 2^WIDTH.
  - depth=0 gives g=2^WIDTH, so out=s_data exactly.
  - Bypass (en=0 at acceptance): the output is the captured s_data unchanged, with identical latency.
- Boundary conditions:
  - lfo at its maximum (2^(WIDTH-1)-1) gives d=1, r=0 for all depth, so the sample passes unchanged.
  - Most negative s_data (-2^(WIDTH-1)) with g=2^WIDTH returns the same value, with no sign flip.
  - Changes to lfo, depth or en affect only samples accepted after the change; in-flight samples are unaffected.
  - If m_ready rises in the same cycle that a new s_valid arrives at a full pipeline, the output and input transfers happen on the same edge.

Decomposition:
- Package `tremolo_pkg`:
  - localparams for the WIDTH/DEPTH_W defaults.
  - A function `trem_gain(lfo, depth)` returning the WIDTH+1-bit g. The bench uses the same function for its reference model.
- One sub-module, `tremolo_gain`: the registered stage-1 gain computation (lfo/depth in, g out, with a ce input). The top level holds the handshake, the product stage and the output stage.

Test Plan (WIDTH=24, DEPTH_W=8):
- depth=0, en=1, lfo=-2^23, s_data=1000, m_ready=1 -> m_data=1000, m_valid high exactly 2 edges after acceptance.
- depth=255, lfo=-2^23 (0x800000), s_data=0x100000 -> g=2^16, m_data=0x001000 (4096).
- depth=128, lfo=0, s_data=-4096 -> g=0xC00000, m_data=-3072; with lfo=0x7FFFFF and any depth -> m_data=s_data.
- Stream of 8 consecutive samples; hold m_ready=0 for 3 cycles mid-stream -> s_ready=0 while the pipeline is full, m_data stable while stalled, all 8 outputs delivered in order with none lost or duplicated.
- en=0, depth=255, lfo=-2^23, s_data=0x7FFFFF -> m_data=0x7FFFFF; then toggle en=1 for the next sample -> only that sample is scaled (0x7FFFFF*2^16>>24 = 0x7FFF).
- Assert rst for 1 cycle with 3 samples in flight -> m_valid=0 and m_data=0 on the following cycle, no stale outputs; a new sample is accepted and output normally after release.
